// File: rtl/apb_xfer_sequencer_if.sv
// Bridge-facing and slave-facing signal bundle of the APB transfer sequencer.
// The slave modport is the sequencer's view; the master modport is the bridge/slave side.
interface apb_xfer_sequencer_if #(
  parameter int RATIO    = 4,
  parameter int logRATIO = 2,
  parameter int DATA_W   = 32
);
  logic                    i_start;
  logic [logRATIO-1:0]     i_slv_sel;
  logic [RATIO-1:0]        i_pready;
  logic [RATIO*DATA_W-1:0] i_prdata;
  logic [RATIO-1:0]        i_pslverr;
  logic [RATIO-1:0]        o_psel;
  logic                    o_penable;
  logic                    o_busy;
  logic                    o_done;
  logic [DATA_W-1:0]       o_prdata;
  logic                    o_pslverr;
  logic                    o_timeout;

  modport master (
    output i_start, i_slv_sel, i_pready, i_prdata, i_pslverr,
    input  o_psel, o_penable, o_busy, o_done, o_prdata, o_pslverr, o_timeout
  );

  modport slave (
    input  i_start, i_slv_sel, i_pready, i_prdata, i_pslverr,
    output o_psel, o_penable, o_busy, o_done, o_prdata, o_pslverr, o_timeout
  );
endinterface

// File: rtl/apb_xfer_sequencer.sv
// APB setup/access sequencer: drives one-hot PSEL and PENABLE for one slave,
// collects its PREADY/PRDATA/PSLVERR and returns a registered one-cycle response.
module apb_xfer_sequencer #(
  parameter int RATIO    = 4,
  parameter int logRATIO = 2,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 4
) (
  input logic                   i_pclk,
  input logic                   i_presetn,
  apb_xfer_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [logRATIO-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RATIO-1:0]    psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic                pslverr_q, pslverr_d;
  logic                timeout_q, timeout_d;

  logic                sel_pready_s;
  logic                sel_pslverr_s;
  logic [DATA_W-1:0]   sel_prdata_s;
  logic                idx_valid_s;

  // Only the latched slave's response reaches the FSM; an out-of-range index selects nothing.
  always_comb begin
    sel_pready_s  = 1'b0;
    sel_pslverr_s = 1'b0;
    sel_prdata_s  = {DATA_W{1'b0}};
    for (int k = 0; k < RATIO; k++) begin
      sel_pready_s  = sel_pready_s  | (bus.i_pready[k]  & (int'(idx_q) == k));
      sel_pslverr_s = sel_pslverr_s | (bus.i_pslverr[k] & (int'(idx_q) == k));
      sel_prdata_s  = sel_prdata_s
                    | ({DATA_W{int'(idx_q) == k}} & bus.i_prdata[k*DATA_W +: DATA_W]);
    end
    idx_valid_s = (int'(idx_q) < RATIO);
  end

  // Next-state and response capture.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d = ST_SETUP;
          idx_d   = bus.i_slv_sel;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (idx_valid_s) begin
          state_d = ST_ACCESS;
        end else begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          prdata_d  = {DATA_W{1'b0}};
          pslverr_d = 1'b1;
          timeout_d = 1'b0;
        end
      end
      ST_ACCESS: begin
        // A PREADY in the last allowed cycle wins over the timeout.
        if (sel_pready_s) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          prdata_d  = sel_prdata_s;
          pslverr_d = sel_pslverr_s;
          timeout_d = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          prdata_d  = {DATA_W{1'b0}};
          pslverr_d = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus strobes are decoded from the next state so they register in step with it.
  always_comb begin
    psel_d = {RATIO{1'b0}};
    for (int k = 0; k < RATIO; k++) begin
      psel_d[k] = ((state_d == ST_SETUP) || (state_d == ST_ACCESS)) && (int'(idx_d) == k);
    end
    penable_d = (state_d == ST_ACCESS);
    busy_d    = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      state_q   <= ST_IDLE;
      idx_q     <= {logRATIO{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      psel_q    <= {RATIO{1'b0}};
      penable_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      prdata_q  <= {DATA_W{1'b0}};
      pslverr_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.o_psel    = psel_q;
  assign bus.o_penable = penable_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_prdata  = prdata_q;
  assign bus.o_pslverr = pslverr_q;
  assign bus.o_timeout = timeout_q;

endmodule

// File: tb/tb_apb_xfer_sequencer.sv
// Scoreboard bench for apb_xfer_sequencer: expected responses are queued at request
// time and compared, including completion cycle, whenever o_done is seen.
module tb_apb_xfer_sequencer;
  localparam int RATIO    = 4;
  localparam int logRATIO = 2;
  localparam int DATA_W   = 32;
  localparam int TIMEOUT  = 16;
  localparam int CNT_W    = 4;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err;
    logic              to;
    int                cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_err;
  exp_t sb[$];
  exp_t mon_e;

  int                wait_cfg [RATIO];
  logic [DATA_W-1:0] data_cfg [RATIO];
  logic [RATIO-1:0]  err_cfg;
  bit                noise;

  apb_xfer_sequencer_if #(.RATIO(RATIO), .logRATIO(logRATIO), .DATA_W(DATA_W)) bus ();

  apb_xfer_sequencer #(
    .RATIO(RATIO), .logRATIO(logRATIO), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .i_pclk    (clk),
    .i_presetn (rst_n),
    .bus       (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk_exp(input int sel, input int c0);
    exp_t e;
    if (wait_cfg[sel] >= TIMEOUT) begin
      e.data = '0;
      e.err  = 1'b1;
      e.to   = 1'b1;
      e.cyc  = c0 + TIMEOUT + 2;
    end else begin
      e.data = data_cfg[sel];
      e.err  = err_cfg[sel];
      e.to   = 1'b0;
      e.cyc  = c0 + 3 + wait_cfg[sel];
    end
    return e;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  always_comb begin
    for (int k = 0; k < RATIO; k++) bus.i_prdata[k*DATA_W +: DATA_W] = data_cfg[k];
  end
  assign bus.i_pslverr = err_cfg;

  // Slave model: PREADY of the accessed slave rises after wait_cfg ACCESS cycles
  initial begin
    int acc_n [RATIO];
    for (int k = 0; k < RATIO; k++) acc_n[k] = 0;
    bus.i_pready = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < RATIO; k++) begin
        if (bus.o_psel[k] && bus.o_penable) begin
          bus.i_pready[k] = (acc_n[k] >= wait_cfg[k]);
          acc_n[k]++;
        end else begin
          acc_n[k] = 0;
          bus.i_pready[k] = noise;
        end
      end
    end
  end

  // Completion monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_done === 1'b1) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("done_prdata",  bus.o_prdata,  mon_e.data);
          check_eq("done_pslverr", bus.o_pslverr, mon_e.err);
          check_eq("done_timeout", bus.o_timeout, mon_e.to);
          check_eq("done_cycle",   cyc,           mon_e.cyc);
        end
      end
    end
  end

  task automatic wait_drain(input string tag);
    for (int i = 0; i < TIMEOUT + 12 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check_eq(tag, sb.size(), 64'd0);
      sb.delete();
    end
  endtask

  task automatic xfer(input int sel, input bit ignore_mode);
    @(negedge clk);
    bus.i_start   = 1'b1;
    bus.i_slv_sel = 2'(sel);
    sb.push_back(mk_exp(sel, cyc));
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int i = 0; i < TIMEOUT + 8 && sb.size() != 0; i++) begin
      if (ignore_mode) begin
        bus.i_start   = bus.o_busy;
        bus.i_slv_sel = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
    end
    bus.i_start = 1'b0;
    if (sb.size() != 0) begin
      check_eq("done_wait", sb.size(), 64'd0);
      sb.delete();
    end
    if (ignore_mode) begin
      @(negedge clk);
      check_eq("no_queued_start", bus.o_busy, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_psel"},    bus.o_psel,    4'b0000);
    check_eq({tag, "_penable"}, bus.o_penable, 1'b0);
    check_eq({tag, "_busy"},    bus.o_busy,    1'b0);
    check_eq({tag, "_done"},    bus.o_done,    1'b0);
    check_eq({tag, "_prdata"},  bus.o_prdata,  32'h0);
    check_eq({tag, "_pslverr"}, bus.o_pslverr, 1'b0);
    check_eq({tag, "_timeout"}, bus.o_timeout, 1'b0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    noise = 1'b0;
    err_cfg = 4'b0000;
    for (int k = 0; k < RATIO; k++) begin
      wait_cfg[k] = 0;
      data_cfg[k] = 32'h1000_0000 + 32'(k);
    end
    rst_n         = 1'b0;
    bus.i_start   = 1'b0;
    bus.i_slv_sel = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Zero-wait read from slave 2 with strobe checks per cycle
    data_cfg[2] = 32'hDEADBEEF;
    @(negedge clk);
    bus.i_start   = 1'b1;
    bus.i_slv_sel = 2'd2;
    sb.push_back(mk_exp(2, cyc));
    @(negedge clk);
    bus.i_start = 1'b0;
    check_eq("zw_c1_psel",    bus.o_psel,    4'b0100);
    check_eq("zw_c1_penable", bus.o_penable, 1'b0);
    check_eq("zw_c1_busy",    bus.o_busy,    1'b1);
    @(negedge clk);
    check_eq("zw_c2_psel",    bus.o_psel,    4'b0100);
    check_eq("zw_c2_penable", bus.o_penable, 1'b1);
    @(negedge clk);
    check_eq("zw_c3_done",    bus.o_done,    1'b1);
    check_eq("zw_c3_psel",    bus.o_psel,    4'b0000);
    check_eq("zw_c3_penable", bus.o_penable, 1'b0);
    check_eq("zw_c3_busy",    bus.o_busy,    1'b0);
    wait_drain("zw_drain");
    @(negedge clk);
    check_eq("zw_done_pulse", bus.o_done,   1'b0);
    check_eq("zw_prdata_hold", bus.o_prdata, 32'hDEADBEEF);

    // Three wait states, then slave error with data
    wait_cfg[1] = 3;
    err_cfg[1]  = 1'b1;
    data_cfg[1] = 32'h1234_5678;
    xfer(1, 1'b0);
    err_cfg[1] = 1'b0;

    // Timeout, then PREADY in the final allowed ACCESS cycle
    wait_cfg[0] = 99;
    xfer(0, 1'b0);
    wait_cfg[0] = TIMEOUT - 1;
    data_cfg[0] = 32'hA5A5_0F0F;
    xfer(0, 1'b0);

    // Isolation: other slaves ready and erroring, start pulses while busy
    noise       = 1'b1;
    err_cfg     = 4'b0111;
    wait_cfg[3] = 4;
    data_cfg[3] = 32'hCAFE_F00D;
    xfer(3, 1'b1);
    noise   = 1'b0;
    err_cfg = 4'b0000;

    // Back-to-back with start held high
    for (int k = 0; k < RATIO; k++) wait_cfg[k] = 0;
    data_cfg[0] = 32'h0000_00A0;
    data_cfg[1] = 32'h0000_00B1;
    data_cfg[2] = 32'h0000_00C2;
    @(negedge clk);
    bus.i_start   = 1'b1;
    bus.i_slv_sel = 2'd0;
    sb.push_back(mk_exp(0, cyc));
    @(negedge clk);
    bus.i_slv_sel = 2'd1;
    sb.push_back(mk_exp(1, cyc + 2));
    repeat (3) @(negedge clk);
    bus.i_slv_sel = 2'd2;
    sb.push_back(mk_exp(2, cyc + 2));
    repeat (3) @(negedge clk);
    bus.i_start = 1'b0;
    wait_drain("b2b_drain");

    // Asynchronous reset in the middle of ACCESS
    wait_cfg[0] = 99;
    @(negedge clk);
    bus.i_start   = 1'b1;
    bus.i_slv_sel = 2'd0;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    check_eq("mid_penable", bus.o_penable, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n       = 1'b1;
    wait_cfg[0] = 1;
    data_cfg[0] = 32'h5555_AAAA;
    xfer(0, 1'b0);

    repeat (3) @(negedge clk);
    check_eq("sb_empty", sb.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
